// File: rtl/fp_pkg.sv
// Shared widths, types and constants for the mini-MIPS FP register file.
package fp_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_NREGS  = 32;
  localparam int FP_ADDR_W = 5;

  typedef logic [FP_DATA_W-1:0] fp_word_t;
  typedef logic [FP_ADDR_W-1:0] fp_reg_addr_t;

  localparam fp_word_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending bits for in-flight FP results; raises stall on dependent reads.
module fp_scoreboard
  import fp_pkg::*;
#(
  parameter int NREGS  = FP_NREGS,
  parameter int ADDR_W = FP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              mtc1_ack,
  input  logic [ADDR_W-1:0] mtc1_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              stall,
  output logic              busy
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             hz_rs;
  logic             hz_rt;

  // Clears first, then the issue set, so a same-address set survives a writeback clear.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)    pending_nxt[wr_addr]   = 1'b0;
    if (mtc1_ack) pending_nxt[mtc1_addr] = 1'b0;
    if (issue_en) pending_nxt[issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_comb begin
    hz_rs = pending[rs_addr] & ~(wr_en && (wr_addr == rs_addr));
    hz_rt = pending[rt_addr] & ~(wr_en && (wr_addr == rt_addr));
    stall = rd_en & (hz_rs | hz_rt);
    busy  = |pending;
  end

endmodule

// File: rtl/fp_regfile.sv
// 32 x 32-bit FP register file: two bypassed read ports, ALU writeback port
// with priority over the mtc1 move port, and a pending-result scoreboard.
module fp_regfile
  import fp_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int NREGS  = FP_NREGS,
  parameter int ADDR_W = FP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mtc1_en,
  input  logic [ADDR_W-1:0] mtc1_addr,
  input  logic [DATA_W-1:0] mtc1_data,
  output logic              mtc1_ack,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              stall,
  output logic              busy
);

  logic [DATA_W-1:0] regs [NREGS];

  // The move port only gets the array when no ALU writeback competes, and never in reset.
  assign mtc1_ack = rst_n & mtc1_en & ~wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(FP_ZERO);
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end else if (mtc1_ack) begin
      regs[mtc1_addr] <= mtc1_data;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    if (wr_en && (wr_addr == rs_addr))           rs_data = wr_data;
    else if (mtc1_ack && (mtc1_addr == rs_addr)) rs_data = mtc1_data;
    if (!rst_n)                                  rs_data = '0;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (wr_en && (wr_addr == rt_addr))           rt_data = wr_data;
    else if (mtc1_ack && (mtc1_addr == rt_addr)) rt_data = mtc1_data;
    if (!rst_n)                                  rt_data = '0;
  end

  fp_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .mtc1_ack  (mtc1_ack),
    .mtc1_addr (mtc1_addr),
    .issue_en  (issue_en),
    .issue_dst (issue_dst),
    .rd_en     (rd_en),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .stall     (stall),
    .busy      (busy)
  );

endmodule

// File: tb/tb_fp_regfile.sv
// Self-checking bench for fp_regfile: directed scenarios plus randomized traffic
// against an array/bit-vector reference model.
module tb_fp_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, mtc1_addr, issue_dst;
  logic        rd_en, wr_en, mtc1_en, issue_en;
  logic [31:0] wr_data, mtc1_data;
  logic [31:0] rs_data, rt_data;
  logic        mtc1_ack, stall, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  fp_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_en     (rd_en),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mtc1_en   (mtc1_en),
    .mtc1_addr (mtc1_addr),
    .mtc1_data (mtc1_data),
    .mtc1_ack  (mtc1_ack),
    .issue_en  (issue_en),
    .issue_dst (issue_dst),
    .stall     (stall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs should be given model state and current inputs.
  function automatic logic m_ack();
    return rst_n && mtc1_en && !wr_en;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst_n) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    if (m_ack() && mtc1_addr == a) return mtc1_data;
    return m_regs[a];
  endfunction

  function automatic logic m_stall();
    logic hs, ht;
    if (!rst_n) return 1'b0;
    hs = m_pend[rs_addr] && !(wr_en && wr_addr == rs_addr);
    ht = m_pend[rt_addr] && !(wr_en && wr_addr == rt_addr);
    return rd_en && (hs || ht);
  endfunction

  function automatic logic m_busy();
    return rst_n && (m_pend != 32'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pend = 32'h0;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; mtc1_en = 0; issue_en = 0;
    rs_addr = 0; rt_addr = 0; wr_addr = 0; mtc1_addr = 0; issue_dst = 0;
    wr_data = 0; mtc1_data = 0;
  endtask

  // Advance one rising edge, update the model from the inputs held across it, return at negedge.
  task automatic clock_edge();
    logic ack;
    @(posedge clk);
    ack = m_ack();
    if (rst_n) begin
      if (wr_en) m_regs[wr_addr] = wr_data;
      else if (ack) m_regs[mtc1_addr] = mtc1_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (ack) m_pend[mtc1_addr] = 1'b0;
      if (issue_en) m_pend[issue_dst] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      n_checks++;
      if (rs_data !== 32'h0) begin
        n_fail++; $display("[TB] FAIL reset_rs addr=%0d got=%h exp=%h", i, rs_data, 32'h0);
      end
      n_checks++;
      if (rt_data !== 32'h0) begin
        n_fail++; $display("[TB] FAIL reset_rt addr=%0d got=%h exp=%h", 31 - i, rt_data, 32'h0);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy);
      end
      clock_edge();
    end
  endtask

  task automatic test_write_bypass();
    idle_inputs();
    wr_en = 1; wr_addr = 3; wr_data = 32'h4040_0000; rs_addr = 3;
    #1;
    n_checks++;
    if (rs_data !== 32'h4040_0000) begin
      n_fail++; $display("[TB] FAIL wr_bypass got=%h exp=%h", rs_data, 32'h4040_0000);
    end
    clock_edge();
    wr_en = 0;
    #1;
    n_checks++;
    if (rs_data !== 32'h4040_0000) begin
      n_fail++; $display("[TB] FAIL wr_stored got=%h exp=%h", rs_data, 32'h4040_0000);
    end
    clock_edge();
  endtask

  task automatic test_arbitration();
    idle_inputs();
    wr_en = 1; wr_addr = 5; wr_data = 32'h3F80_0000;
    mtc1_en = 1; mtc1_addr = 6; mtc1_data = 32'h4000_0000;
    rs_addr = 6; rt_addr = 5;
    #1;
    n_checks++;
    if (mtc1_ack !== 1'b0) begin
      n_fail++; $display("[TB] FAIL arb_ack_blocked got=%b exp=0", mtc1_ack);
    end
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL arb_f6_unbypassed got=%h exp=%h", rs_data, 32'h0);
    end
    clock_edge();
    wr_en = 0;
    #1;
    n_checks++;
    if (mtc1_ack !== 1'b1) begin
      n_fail++; $display("[TB] FAIL arb_ack_retry got=%b exp=1", mtc1_ack);
    end
    n_checks++;
    if (rt_data !== 32'h3F80_0000) begin
      n_fail++; $display("[TB] FAIL arb_f5 got=%h exp=%h", rt_data, 32'h3F80_0000);
    end
    clock_edge();
    mtc1_en = 0;
    #1;
    n_checks++;
    if (rs_data !== 32'h4000_0000) begin
      n_fail++; $display("[TB] FAIL arb_f6_written got=%h exp=%h", rs_data, 32'h4000_0000);
    end
    clock_edge();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue_en = 1; issue_dst = 7;
    clock_edge();
    issue_en = 0; rd_en = 1; rt_addr = 7; rs_addr = 0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sb_stall got=%b exp=1", stall);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sb_busy got=%b exp=1", busy);
    end
    clock_edge();
    wr_en = 1; wr_addr = 7; wr_data = 32'h4120_0000;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sb_stall_drop got=%b exp=0", stall);
    end
    n_checks++;
    if (rt_data !== 32'h4120_0000) begin
      n_fail++; $display("[TB] FAIL sb_rt_bypass got=%h exp=%h", rt_data, 32'h4120_0000);
    end
    clock_edge();
    idle_inputs();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sb_busy_clear got=%b exp=0", busy);
    end
    clock_edge();
  endtask

  task automatic test_set_wins();
    idle_inputs();
    wr_en = 1; wr_addr = 2; wr_data = 32'hC000_0000;
    issue_en = 1; issue_dst = 2;
    clock_edge();
    idle_inputs();
    rd_en = 1; rs_addr = 2; rt_addr = 0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL set_wins_stall got=%b exp=1", stall);
    end
    n_checks++;
    if (rs_data !== 32'hC000_0000) begin
      n_fail++; $display("[TB] FAIL set_wins_data got=%h exp=%h", rs_data, 32'hC000_0000);
    end
    clock_edge();
    idle_inputs();
    wr_en = 1; wr_addr = 2; wr_data = 32'h4080_0000;
    clock_edge();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    wr_en = 1; wr_addr = 4; wr_data = 32'h40A0_0000;
    clock_edge();
    idle_inputs();
    issue_en = 1; issue_dst = 4;
    clock_edge();
    idle_inputs();
    rd_en = 1; rs_addr = 4; rt_addr = 4; mtc1_en = 1; mtc1_addr = 9; mtc1_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL areset_pre busy=%b stall=%b exp=1/1", busy, stall);
    end
    #1;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_busy got=%b exp=0", busy);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_stall got=%b exp=0", stall);
    end
    n_checks++;
    if (rs_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL areset_f4 got=%h exp=%h", rs_data, 32'h0);
    end
    n_checks++;
    if (mtc1_ack !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_ack got=%b exp=0", mtc1_ack);
    end
    clock_edge();
    rst_n = 1;
    mtc1_en = 0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || rs_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL areset_after stall=%b data=%h exp=0/00000000", stall, rs_data);
    end
    n_checks++;
    if (m_regs[9] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL areset_model got=%h exp=%h", m_regs[9], 32'h0);
    end
    wr_en = 1; wr_addr = 4; wr_data = 32'h4110_0000;
    clock_edge();
    idle_inputs();
    rs_addr = 4;
    #1;
    n_checks++;
    if (rs_data !== 32'h4110_0000 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_wb data=%h busy=%b exp=41100000/0", rs_data, busy);
    end
    clock_edge();
  endtask

  task automatic test_random();
    logic [31:0] e_rs, e_rt;
    logic        e_st, e_bz, e_ak;
    for (int n = 0; n < 500; n++) begin
      rd_en     = 1'($urandom);
      rs_addr   = 5'($urandom_range(0, 7));
      rt_addr   = 5'($urandom_range(0, 7));
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      mtc1_en   = ($urandom_range(0, 2) == 0);
      mtc1_addr = 5'($urandom_range(0, 7));
      mtc1_data = $urandom;
      issue_en  = ($urandom_range(0, 2) == 0);
      issue_dst = 5'($urandom_range(0, 7));
      #1;
      e_rs = m_read(rs_addr);
      e_rt = m_read(rt_addr);
      e_st = m_stall();
      e_bz = m_busy();
      e_ak = m_ack();
      n_checks++;
      if (rs_data !== e_rs) begin
        n_fail++; $display("[TB] FAIL rnd_rs it=%0d got=%h exp=%h", n, rs_data, e_rs);
      end
      n_checks++;
      if (rt_data !== e_rt) begin
        n_fail++; $display("[TB] FAIL rnd_rt it=%0d got=%h exp=%h", n, rt_data, e_rt);
      end
      n_checks++;
      if (stall !== e_st) begin
        n_fail++; $display("[TB] FAIL rnd_stall it=%0d got=%b exp=%b", n, stall, e_st);
      end
      n_checks++;
      if (busy !== e_bz) begin
        n_fail++; $display("[TB] FAIL rnd_busy it=%0d got=%b exp=%b", n, busy, e_bz);
      end
      n_checks++;
      if (mtc1_ack !== e_ak) begin
        n_fail++; $display("[TB] FAIL rnd_ack it=%0d got=%b exp=%b", n, mtc1_ack, e_ak);
      end
      clock_edge();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_arbitration();
    test_scoreboard();
    test_set_wins();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_regfile.md
# fp_regfile

Floating-point register file for the mini-MIPS FP datapath: 32 × 32-bit IEEE-754 single registers ($f0–$f31). Two combinational read ports drive the FP ALU operands `a`/`b`. One write port takes the FP ALU `result`; a secondary move port (mtc1) loads values from the integer datapath. A per-register pending scoreboard raises `stall` when a read depends on an FP result still in flight.

## Interface
Parameters:
- `DATA_W`, 32, register width (IEEE-754 single)
- `NREGS`, 32, number of FP registers
- `ADDR_W`, 5, register address width; `NREGS == 2**ADDR_W`

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  reset, asynchronous and active-low
- `rs_addr`  input  ADDR_W  read port A address
- `rt_addr`  input  ADDR_W  read port B address
- `rd_en`  input  1  current instruction reads `rs_addr`/`rt_addr`; qualifies `stall`
- `rs_data`  output  DATA_W  read port A data, to FP ALU `a`
- `rt_data`  output  DATA_W  read port B data, to FP ALU `b`
- `wr_en`  input  1  FP ALU writeback valid
- `wr_addr`  input  ADDR_W  writeback destination
- `wr_data`  input  DATA_W  writeback value (FP ALU `result`)
- `mtc1_en`  input  1  move-to-FP request
- `mtc1_addr`  input  ADDR_W  move destination
- `mtc1_data`  input  DATA_W  move value from integer register
- `mtc1_ack`  output  1  move accepted this cycle
- `issue_en`  input  1  FP op issued; marks destination pending
- `issue_dst`  input  ADDR_W  destination of the issued op
- `stall`  output  1  read hazard on a pending register
- `busy`  output  1  OR of all pending bits

## Operation
- Storage: `NREGS` × `DATA_W` flops. $f0 is an ordinary writable register and is not hardwired to zero.
- Reads are combinational.
  - `rs_data = (wr_en && wr_addr==rs_addr) ? wr_data : regs[rs_addr]`; `rt_data` is formed the same way. This is write-through bypass.
  - An accepted mtc1 write is bypassed the same way when `wr_en` is low.
- Write arbitration:
  - `wr_en` has priority.
  - `mtc1_ack = mtc1_en & ~wr_en`.
  - If `mtc1_ack` is low, the mover holds `mtc1_*` stable and retries.
  - Exactly one array write per edge.
- Scoreboard, one pending bit per register. On each edge, apply in order:
  1. Clear `pending[wr_addr]` if `wr_en`.
  2. Clear `pending[mtc1_addr]` if `mtc1_ack`.
  3. Set `pending[issue_dst]` if `issue_en`.
  - Set wins over clear on the same address.
- Stall:
  - Define `hz(x) = pending[x] & ~(wr_en & wr_addr==x)`.
  - `stall = rd_en & (hz(rs_addr) | hz(rt_addr))`.
  - `stall` is combinational and has no dependence on `issue_en`.
- `busy = |pending` (registered bits, no bypass term).
- Reset: all registers `32'h0000_0000` (+0.0) and all pending bits 0. During reset, `rs_data`/`rt_data` read 0, and `stall`, `busy` and `mtc1_ack` are 0 (mtc1 writes are ignored).
- Reset asserted mid-operation discards in-flight pending state. Writeback arriving after reset release writes normally; its clear of an already-0 bit is harmless.

## Timing
- Read latency 0 cycles (combinational from address and bypass inputs).
- Write latency 1 edge: data is visible from `regs` on the cycle after `wr_en`, and via bypass in the same cycle.
- Pending set takes effect the edge after `issue_en`, so a dependent read in the cycle after issue stalls.
- `stall` drops in the same cycle the matching `wr_en` arrives (bypass).
- mtc1 under a continuous `wr_en` stream waits indefinitely. The FP ALU is single-cycle, so back-to-back writebacks are bounded by issue rate.

## Structure
- Shared package `fp_pkg` holds:
  - `FP_DATA_W = 32`, `FP_NREGS = 32`, `FP_ADDR_W = 5`
  - typedef `fp_word_t` (logic [31:0])
  - typedef `fp_reg_addr_t` (logic [4:0])
  - constant `FP_ZERO = 32'h0000_0000`
- One sub-module, `fp_scoreboard`, holds the pending vector, its set/clear logic, `stall` and `busy`. The array, bypass and arbitration stay in `fp_regfile`.

## Test plan
- Reset then read all 32 addresses → every `rs_data`/`rt_data` = `32'h0`, `busy` = 0.
- `wr_en=1`, `wr_addr=3`, `wr_data=32'h4040_0000` (3.0), with `rs_addr=3` in the same cycle → `rs_data=32'h4040_0000` that cycle; `wr_en=0` next cycle → still `32'h4040_0000`.
- Same cycle `wr_en` to $f5 = `32'h3F80_0000` and `mtc1_en` to $f6 = `32'h4000_0000` → `mtc1_ack=0`, only $f5 written. Next cycle (`wr_en=0`) → `mtc1_ack=1`, $f6 = `32'h4000_0000` one edge later.
- `issue_en`, `issue_dst=7`. Next cycle `rd_en=1`, `rt_addr=7` → `stall=1`, `busy=1`. Then `wr_en` to $f7 with `32'h4120_0000` → `stall=0` in that cycle and `rt_data=32'h4120_0000`. Next cycle `busy=0`.
- Same edge: `wr_en` to $f2 and `issue_en` to $f2 → `pending[2]` stays 1 and a following read of $f2 stalls.
- Set `pending[4]`, assert `rst_n=0` asynchronously mid-cycle → `busy`/`stall` drop immediately and $f4 reads 0; after release, a read of $f4 does not stall.
